bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the seven-segment display driver. Its `bcd_out` drives the display's 16-bit `data_in`, so a binary count or measurement is shown as four decimal digits instead of hex.
- Uses a start/busy/done handshake. The last result is held stable between conversions, so the display never sees intermediate values.

---
 rtl/bin2bcd_seq.sv | 101 ++++++++++
 tb/tb_bin2bcd_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with start/busy/done handshake.
// Optional macro BIN2BCD_SAT_EN: out-of-range results saturate to 9999 instead of wrapping mod 10000.
module bin2bcd_seq #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd_out,
    output logic             ovf
);

    // Handshake: start is sampled only while busy=0; done pulses for one cycle
    // on the edge that updates bcd_out/ovf, and busy is already low in that cycle.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;
    localparam logic [4:0] LAST_CNT = 5'(BIN_W - 1);

    logic [0:0]       state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [19:0]      bcd_q, bcd_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [15:0]      bcd_out_q, bcd_out_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [19:0]      adj_bcd;

    always_comb begin
        adj_bcd = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_bcd[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        bcd_out_d = bcd_out_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                bcd_d = {adj_bcd[18:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    ovf_d   = (bcd_d[19:16] != 4'd0);
`ifdef BIN2BCD_SAT_EN
                    bcd_out_d = ovf_d ? 16'h9999 : bcd_d[15:0];
`else
                    bcd_out_d = bcd_d[15:0];
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            bcd_out_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            bcd_out_q <= bcd_out_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == ST_SHIFT);
    assign done    = done_q;
    assign bcd_out = bcd_out_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Table-driven bench for bin2bcd_seq (BIN_W=14) plus hand-written handshake and reset sequences.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

`ifdef BIN2BCD_SAT_EN
    localparam logic [15:0] EXP_12345 = 16'h9999;
    localparam logic [15:0] EXP_16383 = 16'h9999;
    localparam logic [15:0] EXP_10000 = 16'h9999;
`else
    localparam logic [15:0] EXP_12345 = 16'h2345;
    localparam logic [15:0] EXP_16383 = 16'h6383;
    localparam logic [15:0] EXP_10000 = 16'h0000;
`endif

    bin2bcd_seq #(.BIN_W(14)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge while idle; one-cycle start, then checks latency, busy span and result.
    task automatic run_conv(input string tag, input logic [13:0] v,
                            input logic [15:0] exp_bcd, input logic exp_ovf);
        logic [15:0] prev;
        int          n;
        int          busy_n;
        logic        stable;
        prev   = bcd_out;
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 14'($urandom_range(0, 16383));
        n      = 0;
        busy_n = 0;
        stable = 1'b1;
        while (!done && n < 40) begin
            if (busy) busy_n++;
            if (bcd_out !== prev) stable = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, 14);
        check({tag, " busy_cycles"}, busy_n, 14);
        check({tag, " held_during_busy"}, {31'd0, stable}, 1);
        check({tag, " bcd_out"}, {16'd0, bcd_out}, {16'd0, exp_bcd});
        check({tag, " ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
        check({tag, " busy_at_done"}, {31'd0, busy}, 0);
        @(negedge clk);
        check({tag, " done_single"}, {31'd0, done}, 0);
        check({tag, " bcd_held"}, {16'd0, bcd_out}, {16'd0, exp_bcd});
    endtask

    initial begin
        int n;
        int t1;
        int t2;

        vecs[0]  = '{14'd0,     16'h0000,  1'b0};
        vecs[1]  = '{14'd1234,  16'h1234,  1'b0};
        vecs[2]  = '{14'd9999,  16'h9999,  1'b0};
        vecs[3]  = '{14'd12345, EXP_12345, 1'b1};
        vecs[4]  = '{14'd9,     16'h0009,  1'b0};
        vecs[5]  = '{14'd10,    16'h0010,  1'b0};
        vecs[6]  = '{14'd99,    16'h0099,  1'b0};
        vecs[7]  = '{14'd100,   16'h0100,  1'b0};
        vecs[8]  = '{14'd5000,  16'h5000,  1'b0};
        vecs[9]  = '{14'd16383, EXP_16383, 1'b1};
        vecs[10] = '{14'd10000, EXP_10000, 1'b1};
        vecs[11] = '{14'd8191,  16'h8191,  1'b0};

        // Reset for three cycles and check idle outputs.
        rst    = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst bcd_out", {16'd0, bcd_out}, 0);
        check("rst ovf",     {31'd0, ovf}, 0);
        check("rst busy",    {31'd0, busy}, 0);
        check("rst done",    {31'd0, done}, 0);

        for (int i = 0; i < 12; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
        end

        // Start while busy is ignored and bin_in is not re-sampled.
        start  = 1'b1;
        bin_in = 14'd567;
        @(negedge clk);
        start  = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            if (n == 5) begin
                start  = 1'b1;
                bin_in = 14'd42;
            end else begin
                start  = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("ignore latency", n, 14);
        check("ignore bcd_out", {16'd0, bcd_out}, 32'h0567);
        @(negedge clk);
        check("ignore no_restart", {31'd0, busy}, 0);

        // Start held high: back-to-back conversions 15 cycles apart.
        start  = 1'b1;
        bin_in = 14'd7;
        n = 0;
        @(negedge clk);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        check("b2b first bcd", {16'd0, bcd_out}, 32'h0007);
        bin_in = 14'd8;
        n = 0;
        @(negedge clk);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        t2 = cyc;
        start = 1'b0;
        check("b2b spacing", t2 - t1, 15);
        check("b2b second bcd", {16'd0, bcd_out}, 32'h0008);
        @(negedge clk);

        // Reset mid-conversion returns outputs to reset values immediately.
        start  = 1'b1;
        bin_in = 14'd4321;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst busy", {31'd0, busy}, 1);
        rst = 1'b0;
        #1;
        check("midrst busy",    {31'd0, busy}, 0);
        check("midrst done",    {31'd0, done}, 0);
        check("midrst bcd_out", {16'd0, bcd_out}, 0);
        check("midrst ovf",     {31'd0, ovf}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst busy", {31'd0, busy}, 0);
        run_conv("after_rst", 14'd4321, 16'h4321, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
